// File: rtl/pad_cond_pkg.sv
// pad_cond_pkg
// Shared defaults and helpers for the pad input conditioner.
//   DEF_SYNC_STAGES     : default synchronizer depth (legal 2..4)
//   DEF_DEBOUNCE_CYCLES : default debounce length (0 = bypass)
//   DEF_RESET_LEVEL     : default level loaded at reset
//   cnt_width()         : width of the per-bit debounce counter
package pad_cond_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam bit DEF_RESET_LEVEL     = 1'b0;

    // Counter must hold 0..deb; a zero-length debounce still gets a legal
    // one-bit width so that declarations elaborate, even though no counter
    // is built in that case.
    function automatic int cnt_width(input int deb);
        if (deb < 1) begin
            return 1;
        end
        return $clog2(deb + 1);
    endfunction

endpackage

// File: rtl/pad_debounce_bit.sv
// pad_debounce_bit
// Conditions a single asynchronous pad bit: synchronizer chain, debounce
// counter, debounced level and one-cycle edge pulses.
// Ports:
//   clock   : single clock for all state
//   reset_n : asynchronous active-low reset
//   pad_in  : raw pad value, asynchronous to clock
//   level   : debounced, synchronized level
//   rise    : one-cycle pulse the cycle after level goes 0->1
//   fall    : one-cycle pulse the cycle after level goes 1->0
module pad_debounce_bit
    import pad_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit RESET_LEVEL     = DEF_RESET_LEVEL
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pad_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync;
    logic                   level_p1;

    // Stage 0: metastability chain; only the last flop is used downstream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    // Stage 1: debounced level.
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    level <= RESET_LEVEL;
                end else begin
                    level <= sync;
                end
            end
        end else begin : g_debounce
            localparam int CW = cnt_width(DEBOUNCE_CYCLES);
            // The increment that would land on DEBOUNCE_CYCLES is the one that
            // flips level instead, so the counter never exceeds its range.
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cnt   <= '0;
                    level <= RESET_LEVEL;
                end else if (sync == level) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    level <= ~level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

    // Stage 2: edge pulses from level versus its delayed copy. The delayed
    // copy resets to the same value as level, so reset never looks like an
    // edge; rise and fall are mutually exclusive by construction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_p1 <= RESET_LEVEL;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            level_p1 <= level;
            rise     <= level & ~level_p1;
            fall     <= ~level & level_p1;
        end
    end

endmodule

// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner
// WIDTH independent pad input conditioners with sticky pending flags and
// a single combined interrupt.
// Ports:
//   clock    : single clock for all state
//   reset_n  : asynchronous active-low reset (release used as-is)
//   pad_in   : raw pad values, asynchronous to clock
//   pend_clr : write-one-to-clear for pend bits
//   irq_en   : per-bit interrupt enable
//   level    : debounced, synchronized pad levels
//   rise     : one-cycle pulse per bit on 0->1 of level
//   fall     : one-cycle pulse per bit on 1->0 of level
//   pend     : sticky per-bit event flag, set by rise or fall
//   irq      : registered OR of (pend & irq_en)
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit RESET_LEVEL     = DEF_RESET_LEVEL
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] pend_clr,
    input  logic [WIDTH-1:0] irq_en,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pend,
    output logic             irq
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pad_debounce_bit #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_LEVEL    (RESET_LEVEL)
            ) u_bit (
                .clock  (clock),
                .reset_n(reset_n),
                .pad_in (pad_in[i]),
                .level  (level[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
            );
        end
    endgenerate

    // Stage 3: pending flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | rise | fall;
        end
    end

    // Stage 4: interrupt, one cycle behind pend / irq_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pend & irq_en);
        end
    end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Bench for pad_input_conditioner: three configurations side by side,
// directed scenarios followed by random pad activity, all compared every
// cycle against a behavioural model of the conditioning rules.
module tb_pad_input_conditioner;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic [3:0] pad [3];
    logic [3:0] clr [3];
    logic [3:0] en  [3];

    logic [3:0] lvl_a, rise_a, fall_a, pend_a;
    logic       irq_a;
    logic [1:0] lvl_b, rise_b, fall_b, pend_b;
    logic       irq_b;
    logic       lvl_c, rise_c, fall_c, pend_c;
    logic       irq_c;

    // config 0: WIDTH 4, SYNC 2, DEB 4, reset level 0
    // config 1: WIDTH 2, SYNC 2, DEB 0, reset level 0
    // config 2: WIDTH 1, SYNC 3, DEB 5, reset level 1
    localparam int   CS  [3] = '{2, 2, 3};
    localparam int   CD  [3] = '{4, 0, 5};
    localparam int   CW  [3] = '{4, 2, 1};
    localparam logic CRL [3] = '{1'b0, 1'b0, 1'b1};

    pad_input_conditioner #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .pad_in(pad[0]), .pend_clr(clr[0]), .irq_en(en[0]),
        .level(lvl_a), .rise(rise_a), .fall(fall_a), .pend(pend_a), .irq(irq_a));

    pad_input_conditioner #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .RESET_LEVEL(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .pad_in(pad[1][1:0]), .pend_clr(clr[1][1:0]), .irq_en(en[1][1:0]),
        .level(lvl_b), .rise(rise_b), .fall(fall_b), .pend(pend_b), .irq(irq_b));

    pad_input_conditioner #(.WIDTH(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(5), .RESET_LEVEL(1'b1)) dut_c (
        .clock(clock), .reset_n(reset_n), .pad_in(pad[2][0]), .pend_clr(clr[2][0]), .irq_en(en[2][0]),
        .level(lvl_c), .rise(rise_c), .fall(fall_c), .pend(pend_c), .irq(irq_c));

    logic [3:0] o_lvl [3];
    logic [3:0] o_rise[3];
    logic [3:0] o_fall[3];
    logic [3:0] o_pend[3];
    logic       o_irq [3];

    assign o_lvl[0]  = lvl_a;               assign o_lvl[1]  = {2'b00, lvl_b};
    assign o_lvl[2]  = {3'b000, lvl_c};
    assign o_rise[0] = rise_a;              assign o_rise[1] = {2'b00, rise_b};
    assign o_rise[2] = {3'b000, rise_c};
    assign o_fall[0] = fall_a;              assign o_fall[1] = {2'b00, fall_b};
    assign o_fall[2] = {3'b000, fall_c};
    assign o_pend[0] = pend_a;              assign o_pend[1] = {2'b00, pend_b};
    assign o_pend[2] = {3'b000, pend_c};
    assign o_irq[0]  = irq_a;               assign o_irq[1]  = irq_b;
    assign o_irq[2]  = irq_c;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: pad sample history per bit; sync is the pad value
    // seen SYNC edges ago; level flips once sync has disagreed with it for
    // DEB consecutive edges (or simply copies sync when DEB is 0).
    logic [15:0] ph      [3][4];
    logic        m_lvl   [3][4];
    logic        m_lprev [3][4];
    logic        m_rise  [3][4];
    logic        m_fall  [3][4];
    logic        m_pend  [3][4];
    int          m_run   [3][4];
    logic        m_irq   [3];

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_irq[c] = 1'b0;
            for (int b = 0; b < 4; b++) begin
                ph[c][b]      = {16{CRL[c]}};
                m_lvl[c][b]   = CRL[c];
                m_lprev[c][b] = CRL[c];
                m_rise[c][b]  = 1'b0;
                m_fall[c][b]  = 1'b0;
                m_pend[c][b]  = 1'b0;
                m_run[c][b]   = 0;
            end
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 3; c++) begin
            logic acc;
            acc = 1'b0;
            for (int b = 0; b < CW[c]; b++) acc = acc | (m_pend[c][b] & en[c][b]);
            m_irq[c] = acc;
            for (int b = 0; b < CW[c]; b++) begin
                logic s, nr, nf, np;
                s  = ph[c][b][CS[c]-1];
                nr = m_lvl[c][b] & ~m_lprev[c][b];
                nf = ~m_lvl[c][b] & m_lprev[c][b];
                np = (m_pend[c][b] & ~clr[c][b]) | m_rise[c][b] | m_fall[c][b];
                m_lprev[c][b] = m_lvl[c][b];
                if (CD[c] == 0) begin
                    m_lvl[c][b] = s;
                end else if (s != m_lvl[c][b]) begin
                    m_run[c][b]++;
                    if (m_run[c][b] == CD[c]) begin
                        m_lvl[c][b] = ~m_lvl[c][b];
                        m_run[c][b] = 0;
                    end
                end else begin
                    m_run[c][b] = 0;
                end
                m_rise[c][b] = nr;
                m_fall[c][b] = nf;
                m_pend[c][b] = np;
                ph[c][b]     = {ph[c][b][14:0], pad[c][b]};
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < 3; c++) begin
            logic [3:0] el, er, ef, ep;
            el = '0; er = '0; ef = '0; ep = '0;
            for (int b = 0; b < CW[c]; b++) begin
                el[b] = m_lvl[c][b];
                er[b] = m_rise[c][b];
                ef[b] = m_fall[c][b];
                ep[b] = m_pend[c][b];
            end
            chk($sformatf("cfg%0d_level", c), 32'(o_lvl[c]),  32'(el));
            chk($sformatf("cfg%0d_rise",  c), 32'(o_rise[c]), 32'(er));
            chk($sformatf("cfg%0d_fall",  c), 32'(o_fall[c]), 32'(ef));
            chk($sformatf("cfg%0d_pend",  c), 32'(o_pend[c]), 32'(ep));
            chk($sformatf("cfg%0d_irq",   c), 32'(o_irq[c]),  32'(m_irq[c]));
            chk($sformatf("cfg%0d_rise_and_fall", c), 32'(o_rise[c] & o_fall[c]), 32'd0);
        end
    endtask

    // One clock edge: advance the model with the inputs held across the
    // edge, then sample the DUTs just after it.
    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        reset_n = 1'b0;
        pad[0] = 4'h0; pad[1] = 4'h0; pad[2] = 4'h1;
        clr[0] = 4'h0; clr[1] = 4'h0; clr[2] = 4'h0;
        en[0]  = 4'h0; en[1]  = 4'h0; en[2]  = 4'h0;
        model_reset();
        repeat (3) cyc();
        chk("reset_level_a", 32'(lvl_a), 32'h0);
        chk("reset_level_c", 32'(lvl_c), 32'h1);
        chk("reset_pend_a",  32'(pend_a), 32'h0);
        reset_n = 1'b1;
        repeat (2) cyc();

        // Clean rising step on bit 0 of config 0: level at edge 6, rise at 7.
        en[0]     = 4'b0001;
        pad[0][0] = 1'b1;
        repeat (5) cyc();
        chk("step_level_e5", 32'(lvl_a[0]), 32'h0);
        cyc();
        chk("step_level_e6", 32'(lvl_a[0]), 32'h1);
        chk("step_rise_e6",  32'(rise_a[0]), 32'h0);
        cyc();
        chk("step_rise_e7",  32'(rise_a[0]), 32'h1);
        cyc();
        chk("step_rise_e8",  32'(rise_a[0]), 32'h0);
        chk("step_pend_e8",  32'(pend_a[0]), 32'h1);
        cyc();
        chk("step_irq_e9",   32'(irq_a), 32'h1);

        // Glitch of 3 cycles on bit 1 is rejected.
        pad[0][1] = 1'b1;
        repeat (3) cyc();
        pad[0][1] = 1'b0;
        repeat (8) cyc();
        chk("glitch_level", 32'(lvl_a[1]), 32'h0);
        chk("glitch_pend",  32'(pend_a[1]), 32'h0);

        // Clear coincident with a new fall keeps pend; a lone clear drops it.
        pad[0][0] = 1'b0;
        repeat (7) cyc();
        chk("clr_fall_pulse", 32'(fall_a[0]), 32'h1);
        clr[0] = 4'b0001;
        cyc();
        chk("clr_vs_set_pend", 32'(pend_a[0]), 32'h1);
        cyc();
        chk("clr_alone_pend", 32'(pend_a[0]), 32'h0);
        chk("clr_alone_irq_lag", 32'(irq_a), 32'h1);
        clr[0] = 4'b0000;
        cyc();
        chk("clr_irq_low", 32'(irq_a), 32'h0);

        // Reset mid-count discards the count.
        pad[0][0] = 1'b1;
        repeat (5) cyc();
        reset_n = 1'b0;
        #1;
        chk("midrst_level", 32'(lvl_a[0]), 32'h0);
        chk("midrst_edges", 32'(rise_a | fall_a), 32'h0);
        cyc();
        reset_n = 1'b1;
        repeat (5) cyc();
        chk("postrst_level_e5", 32'(lvl_a[0]), 32'h0);
        cyc();
        chk("postrst_level_e6", 32'(lvl_a[0]), 32'h1);
        cyc();
        chk("postrst_rise", 32'(rise_a[0]), 32'h1);

        // Multi-bit pend and masked irq.
        pad[0] = 4'b0000;
        en[0]  = 4'b0100;
        repeat (10) cyc();
        clr[0] = 4'hF;
        cyc();
        clr[0] = 4'h0;
        cyc();
        chk("multi_pend_clean", 32'(pend_a), 32'h0);
        pad[0] = 4'b0101;
        repeat (8) cyc();
        chk("multi_pend", 32'(pend_a), 32'h5);
        cyc();
        chk("multi_irq", 32'(irq_a), 32'h1);
        clr[0] = 4'b0100;
        cyc();
        chk("multi_pend_after_clr", 32'(pend_a), 32'h1);
        clr[0] = 4'b0000;
        cyc();
        chk("multi_irq_off", 32'(irq_a), 32'h0);

        // Bypass configuration: level follows after 3 edges, fall pulses.
        pad[1] = 4'b0001;
        repeat (2) cyc();
        chk("byp_level_e2", 32'(lvl_b[0]), 32'h0);
        cyc();
        chk("byp_level_e3", 32'(lvl_b[0]), 32'h1);
        cyc();
        chk("byp_rise", 32'(rise_b[0]), 32'h1);
        pad[1] = 4'b0000;
        repeat (3) cyc();
        chk("byp_level_low", 32'(lvl_b[0]), 32'h0);
        cyc();
        chk("byp_fall", 32'(fall_b[0]), 32'h1);

        // Random activity on all configurations with occasional resets.
        repeat (3000) begin
            for (int c = 0; c < 3; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 7) == 0) pad[c][b] = ~pad[c][b];
                end
                clr[c] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                if ($urandom_range(0, 31) == 0) en[c] = 4'($urandom);
            end
            reset_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
